// File: rtl/addsub_iter_if.sv
// Handshake and operand/result bundle for the iterative add/subtract unit.
interface addsub_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic             use_cin;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             n;
  logic             z;
  logic             v;
  logic             c;

  modport master (
    output start, op_sub, use_cin, cin, a, b,
    input  ready, done, y, n, z, v, c
  );

  modport slave (
    input  start, op_sub, use_cin, cin, a, b,
    output ready, done, y, n, z, v, c
  );
endinterface

// File: rtl/addsub_iter.sv
// Multi-cycle add/subtract with SPARC icc flags; the carry chain is resolved one
// CHUNK-bit slice per clock, LSB slice first.
module addsub_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  addsub_iter_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

  typedef enum logic {StIdle, StRun} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d, acc_q, acc_d, y_q, y_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             a_msb_q, a_msb_d, bx_msb_q, bx_msb_d;
  logic             carry_q, carry_d, sub_q, sub_d, done_q, done_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;
  logic [CHUNK:0]   sum;
  logic             k;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    bx_d     = bx_q;
    acc_d    = acc_q;
    y_d      = y_q;
    idx_d    = idx_q;
    a_msb_d  = a_msb_q;
    bx_msb_d = bx_msb_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    done_d   = 1'b0;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    k        = bus.use_cin & bus.cin;
    sum      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bx_q[CHUNK-1:0]} + (CHUNK + 1)'(carry_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.a;
          bx_d     = bus.op_sub ? ~bus.b : bus.b;
          a_msb_d  = bus.a[WIDTH-1];
          bx_msb_d = bx_d[WIDTH-1];
          carry_d  = bus.op_sub ? ~k : k;
          sub_d    = bus.op_sub;
          idx_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Operands shift down so the active slice is always at the bottom; the
        // accumulator fills from the top and holds the full sum after NCHUNK steps.
        a_d     = a_q >> CHUNK;
        bx_d    = bx_q >> CHUNK;
        acc_d   = (acc_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = sum[CHUNK];
        idx_d   = idx_q + IW'(1);
        if (idx_q == LastIdx) begin
          y_d     = acc_d;
          n_d     = acc_d[WIDTH-1];
          z_d     = (acc_d == '0);
          v_d     = (a_msb_q == bx_msb_q) & (acc_d[WIDTH-1] != a_msb_q);
          c_d     = sub_q ^ sum[CHUNK];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      bx_q     <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      done_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      a_msb_q  <= a_msb_d;
      bx_msb_q <= bx_msb_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      done_q   <= done_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = done_q;
  assign bus.y     = y_q;
  assign bus.n     = n_q;
  assign bus.z     = z_q;
  assign bus.v     = v_q;
  assign bus.c     = c_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Drives three configurations (32/8, 32/32, 16/4) and compares against an
// arithmetic reference model computed on 64-bit integers.
module tb_addsub_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_v[3], op_sub_v[3], use_cin_v[3], cin_v[3];
  logic [31:0] a_v[3], b_v[3];
  logic        ready_v[3], done_v[3], n_v[3], z_v[3], v_v[3], c_v[3];
  logic [31:0] y_v[3];

  logic [31:0] ey[3];
  logic        en[3], ez[3], ev[3], ec[3];

  int checks   = 0;
  int failures = 0;

  addsub_iter_if #(.WIDTH(32)) bus0 ();
  addsub_iter_if #(.WIDTH(32)) bus1 ();
  addsub_iter_if #(.WIDTH(16)) bus2 ();

  addsub_iter #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  addsub_iter #(.WIDTH(32), .CHUNK(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  addsub_iter #(.WIDTH(16), .CHUNK(4))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start = start_v[0];  assign bus0.op_sub = op_sub_v[0];
  assign bus0.use_cin = use_cin_v[0];  assign bus0.cin = cin_v[0];
  assign bus0.a = a_v[0];  assign bus0.b = b_v[0];
  assign bus1.start = start_v[1];  assign bus1.op_sub = op_sub_v[1];
  assign bus1.use_cin = use_cin_v[1];  assign bus1.cin = cin_v[1];
  assign bus1.a = a_v[1];  assign bus1.b = b_v[1];
  assign bus2.start = start_v[2];  assign bus2.op_sub = op_sub_v[2];
  assign bus2.use_cin = use_cin_v[2];  assign bus2.cin = cin_v[2];
  assign bus2.a = a_v[2][15:0];  assign bus2.b = b_v[2][15:0];

  assign ready_v[0] = bus0.ready;  assign done_v[0] = bus0.done;  assign y_v[0] = bus0.y;
  assign n_v[0] = bus0.n;  assign z_v[0] = bus0.z;  assign v_v[0] = bus0.v;  assign c_v[0] = bus0.c;
  assign ready_v[1] = bus1.ready;  assign done_v[1] = bus1.done;  assign y_v[1] = bus1.y;
  assign n_v[1] = bus1.n;  assign z_v[1] = bus1.z;  assign v_v[1] = bus1.v;  assign c_v[1] = bus1.c;
  assign ready_v[2] = bus2.ready;  assign done_v[2] = bus2.done;  assign y_v[2] = {16'h0, bus2.y};
  assign n_v[2] = bus2.n;  assign z_v[2] = bus2.z;  assign v_v[2] = bus2.v;  assign c_v[2] = bus2.c;

  function automatic int width_of(input int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 1) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input int k, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cfg=%0d got=%0h exp=%0h t=%0t", tag, k, got, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic; borrow is a < b + k, overflow from operand signs.
  task automatic model(input int k, input logic sub, input logic usec, input logic ci,
                       input logic [31:0] a, input logic [31:0] b);
    int          w;
    logic [63:0] mask, aa, bb, kk, full, res;
    logic        sa, sb, sy;
    w    = width_of(k);
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = {32'h0, b} & mask;
    kk   = {63'h0, usec & ci};
    if (!sub) begin
      full  = aa + bb + kk;
      ec[k] = full[w];
    end else begin
      full  = aa - bb - kk;
      ec[k] = (aa < bb + kk);
    end
    res   = full & mask;
    sa    = aa[w-1];
    sb    = bb[w-1];
    sy    = res[w-1];
    ey[k] = res[31:0];
    en[k] = sy;
    ez[k] = (res == 64'h0);
    ev[k] = sub ? ((sa != sb) && (sy != sa)) : ((sa == sb) && (sy != sa));
  endtask

  // Called #1 after an edge with the unit ready; returns #1 after the start edge.
  task automatic issue(input int k, input logic sub, input logic usec, input logic ci,
                       input logic [31:0] a, input logic [31:0] b);
    check("ready_at_start", k, ready_v[k], 1);
    model(k, sub, usec, ci, a, b);
    op_sub_v[k]  = sub;
    use_cin_v[k] = usec;
    cin_v[k]     = ci;
    a_v[k]       = a;
    b_v[k]       = b;
    start_v[k]   = 1'b1;
    @(posedge clk);
    #1;
    start_v[k]   = 1'b0;
    a_v[k]       = $urandom;
    b_v[k]       = $urandom;
    op_sub_v[k]  = 1'($urandom);
    use_cin_v[k] = 1'($urandom);
    cin_v[k]     = 1'($urandom);
  endtask

  task automatic finish_op(input int k, input logic poke);
    for (int cyc = 1; cyc < lat_of(k); cyc++) begin
      @(posedge clk);
      #1;
      start_v[k] = 1'b0;
      check("busy_ready", k, ready_v[k], 0);
      check("busy_done", k, done_v[k], 0);
      if (poke && cyc == 1) begin
        start_v[k] = 1'b1;
        a_v[k]     = $urandom;
        b_v[k]     = $urandom;
      end
    end
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    check("done_pulse", k, done_v[k], 1);
    check("done_ready", k, ready_v[k], 1);
    check("y", k, y_v[k], ey[k]);
    check("n", k, n_v[k], en[k]);
    check("z", k, z_v[k], ez[k]);
    check("v", k, v_v[k], ev[k]);
    check("c", k, c_v[k], ec[k]);
  endtask

  task automatic idle_tail(input int k);
    @(posedge clk);
    #1;
    check("done_drop", k, done_v[k], 0);
    check("idle_ready", k, ready_v[k], 1);
    check("y_hold", k, y_v[k], ey[k]);
  endtask

  task automatic check_reset_vals(input int k);
    check("rst_y", k, y_v[k], 0);
    check("rst_flags", k, {n_v[k], z_v[k], v_v[k], c_v[k]}, 0);
    check("rst_done", k, done_v[k], 0);
    check("rst_ready", k, ready_v[k], 1);
  endtask

  initial begin
    logic [31:0] m, mp, ra, rb;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 0; op_sub_v[k] = 0; use_cin_v[k] = 0; cin_v[k] = 0;
      a_v[k] = 0; b_v[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("post_rst_done", k, done_v[k], 0);

    for (int k = 0; k < 3; k++) begin
      m  = (width_of(k) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      mp = m >> 1;
      issue(k, 0, 0, 0, 5, 3);          finish_op(k, 0); idle_tail(k);
      issue(k, 0, 0, 0, mp, 1);         finish_op(k, 0); idle_tail(k);
      issue(k, 1, 0, 0, 5, 5);          finish_op(k, 0);
      issue(k, 1, 0, 0, 3, 5);          finish_op(k, 0); idle_tail(k);
      issue(k, 0, 1, 1, m, 0);          finish_op(k, 0); idle_tail(k);
      issue(k, 1, 1, 1, 10, 3);         finish_op(k, 0); idle_tail(k);
      issue(k, 1, 0, 1, 10, 3);         finish_op(k, 0); idle_tail(k);
      issue(k, 0, 0, 0, 32'h1234, 32'h1111); finish_op(k, 1); idle_tail(k);

      // Reset two cycles into an operation.
      issue(k, 0, 0, 0, 7, 9);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_vals(k);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check("no_done_after_rst", k, done_v[k], 0);
      end
      check("ready_after_rst", k, ready_v[k], 1);

      for (int i = 0; i < 30; i++) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? m : mp;
        if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? ra : 32'h0;
        issue(k, 1'($urandom), 1'($urandom), 1'($urandom), ra, rb);
        finish_op(k, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) != 0 || i == 29) idle_tail(k);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_iter.md
# addsub_iter

Parametrised, multi-cycle integer add/subtract unit for the SPARC integer datapath. It generalises the single-cycle 32-bit adder in four ways: operand width is a parameter, carry-in is supported, subtract is supported, and the SPARC icc flags (N, Z, V, C) are produced. The carry chain is split into CHUNK-bit slices, one slice per clock, so long carry paths stay off the critical path. A start/ready/done handshake lets the control unit stall the pipeline while an operation is in flight.

## Interface
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits added per cycle. Must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request an operation; sampled only while ready=1.
- op_sub  input  1  0 = add, 1 = subtract (a - b).
- use_cin  input  1  1 = include cin (ADDX/SUBX); 0 = ignore cin.
- cin  input  1  carry-in, normally icc.C.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse when y and the flags are updated.
- y  output  WIDTH  result.
- n  output  1  negative flag, y[WIDTH-1].
- z  output  1  zero flag, y == 0.
- v  output  1  signed overflow flag.
- c  output  1  carry flag for add; borrow flag for subtract.

## Operation
- The unit has two states, IDLE and RUN. Reset puts it in IDLE.
- **IDLE**
  - ready=1.
  - On start=1, the unit latches a and bx = op_sub ? ~b : b.
  - It computes k = use_cin & cin and sets the initial carry to op_sub ? ~k : k.
  - It then clears the slice index and moves to RUN.
- **RUN**
  - ready=0.
  - Each cycle, slice i (bits i*CHUNK .. i*CHUNK+CHUNK-1) is added with the running carry.
  - The slice sum is written to an internal accumulator and the carry-out is kept for the next slice.
  - After slice NCHUNK-1, the unit registers y from the accumulator and computes the flags:
    - n = y[MSB].
    - z = (y == 0).
    - v = (a[MSB] == bx[MSB]) & (y[MSB] != a[MSB]).
    - c = op_sub ? ~cout : cout, where cout is the final carry-out.
  - It then pulses done and returns to IDLE.
- Arithmetic is modulo 2^WIDTH, so the result wraps with no saturation.
- SUBX computes a - b - cin.
- start while ready=0 is ignored. It is neither queued nor able to corrupt the operation in flight.
- y and the flags hold their values between completions. They change only on the done edge.
- Operand inputs may change freely after the start cycle because the unit works from its latched copies.
- **Reset while idle:** y=0, n=z=v=c=0, done=0, ready=1.
- **Reset mid-operation:** the operation is aborted, no done is produced, and the outputs return to these reset values.

## Timing
- Edge 0 is the edge that samples start=1 while ready=1. After it, ready=0.
- Slice i is added at edge i+1, for i = 0 .. NCHUNK-1.
- At edge NCHUNK:
  - y and the flags are registered.
  - done=1 for exactly one cycle.
  - ready=1 in the same cycle.
- Latency from start to done is NCHUNK cycles. With WIDTH=32 and CHUNK=8 this is 4 cycles. With CHUNK=WIDTH it is 1 cycle.
- Back-to-back operation: start may be asserted in the done cycle and is accepted at that edge. Sustained throughput is one operation per NCHUNK cycles.
- done is never high during reset or during the cycle after reset deasserts.

## Test plan
- **Add, no flags:** WIDTH=32, CHUNK=8, a=5, b=3, add, use_cin=0 -> done exactly 4 cycles after the start edge, y=0x00000008, n=z=v=c=0, ready low for the 4 cycles in between.
- **Signed overflow:** a=0x7FFFFFFF, b=1, add -> y=0x80000000, n=1, v=1, z=0, c=0.
- **Subtract, equal and borrow:**
  - a=5, b=5, sub -> y=0, z=1, c=0.
  - Then a=3, b=5, sub, started in the done cycle -> y=0xFFFFFFFE, n=1, c=1, v=0, with the second done 4 cycles after the first.
- **Carry-in:**
  - ADDX a=0xFFFFFFFF, b=0, cin=1 -> y=0, z=1, c=1.
  - SUBX a=10, b=3, cin=1 -> y=6, c=0.
  - The same SUBX with use_cin=0 -> y=7.
- **Busy and reset:**
  - Pulse start with new operands 2 cycles into an operation -> ignored, and the original result is delivered on schedule.
  - Assert rst 2 cycles into an operation -> no done, all outputs 0, ready=1.
- **Parameter sweep:**
  - Repeat the add and sub cases with CHUNK=32 -> latency 1.
  - Repeat with WIDTH=16, CHUNK=4 -> latency 4, results correct modulo 2^16.
  - Check all cases against a reference model using random operands.
